// File: rtl/simmem_write_delay_calc.sv
// Write-response delay model for a simulated DRAM: each accepted write holds a slot
// until its row-dependent latency has elapsed and all of its data beats have arrived.
module simmem_write_delay_calc #(
  parameter int NumWSlots         = 6,
  parameter int DelayWidth        = 6,
  parameter int RowHitCost        = 4,
  parameter int PrechargeCost     = 2,
  parameter int ActivationCost    = 1,
  parameter int RowBufferLenWidth = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        waddr_valid_i,
  output logic        waddr_ready_o,
  input  logic [4:0]  waddr_iid_i,
  input  logic [15:0] waddr_addr_i,
  input  logic [1:0]  waddr_burst_len_i,
  input  logic        wdata_valid_i,
  output logic        wdata_ready_o,
  output logic        release_valid_o,
  output logic [4:0]  release_iid_o,
  input  logic        release_ready_i
);
  localparam int AddrW = 16;
  localparam int IidW  = 5;
  localparam int BeatW = 3;
  localparam int IdxW  = (NumWSlots > 1) ? $clog2(NumWSlots) : 1;
  localparam int CntW  = $clog2(NumWSlots + 1);
  localparam int RowW  = AddrW - RowBufferLenWidth;

  // Per-slot state
  logic [NumWSlots-1:0]                 occ_q, occ_d;
  logic [NumWSlots-1:0][IidW-1:0]       iid_q, iid_d;
  logic [NumWSlots-1:0][DelayWidth-1:0] cnt_q, cnt_d;
  logic [NumWSlots-1:0][BeatW-1:0]      beats_q, beats_d;

  // In-order queue of slots still waiting for write data
  logic [NumWSlots-1:0][IdxW-1:0] fifo_q, fifo_d;
  logic [IdxW-1:0]                head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]                qcnt_q, qcnt_d;

  logic [RowW-1:0] row_q, row_d;
  logic            row_vld_q, row_vld_d;

  logic [RowW-1:0]       req_row;
  logic [DelayWidth-1:0] delay_m1;
  logic [IdxW-1:0]       alloc_idx, rel_idx, head_slot;
  logic [NumWSlots-1:0]  elig;
  logic                  alloc_fire, beat_fire, rel_fire, pop;
  logic                  unused_addr;

  assign unused_addr = ^waddr_addr_i[RowBufferLenWidth-1:0];
  assign req_row     = waddr_addr_i[AddrW-1:RowBufferLenWidth];

  function automatic logic [IdxW-1:0] ptr_inc(input logic [IdxW-1:0] p);
    return (p == IdxW'(NumWSlots - 1)) ? '0 : p + IdxW'(1);
  endfunction

  always_comb begin
    if (!row_vld_q)             delay_m1 = DelayWidth'(ActivationCost + RowHitCost - 1);
    else if (req_row == row_q)  delay_m1 = DelayWidth'(RowHitCost - 1);
    else                        delay_m1 = DelayWidth'(PrechargeCost + ActivationCost + RowHitCost - 1);
  end

  // Lowest-index free slot and lowest-index eligible slot
  always_comb begin
    alloc_idx = '0;
    rel_idx   = '0;
    for (int i = NumWSlots - 1; i >= 0; i--) begin
      elig[i] = occ_q[i] && (cnt_q[i] == '0) && (beats_q[i] == '0);
      if (!occ_q[i]) alloc_idx = IdxW'(i);
      if (elig[i])   rel_idx   = IdxW'(i);
    end
  end

  assign waddr_ready_o   = ~&occ_q;
  assign wdata_ready_o   = (qcnt_q != '0);
  assign release_valid_o = |elig;
  assign release_iid_o   = release_valid_o ? iid_q[rel_idx] : '0;

  assign head_slot  = fifo_q[head_q];
  assign alloc_fire = waddr_valid_i & waddr_ready_o;
  assign beat_fire  = wdata_valid_i & wdata_ready_o;
  assign rel_fire   = release_valid_o & release_ready_i;
  assign pop        = beat_fire && (beats_q[head_slot] == BeatW'(1));

  always_comb begin
    occ_d     = occ_q;
    iid_d     = iid_q;
    cnt_d     = cnt_q;
    beats_d   = beats_q;
    fifo_d    = fifo_q;
    head_d    = head_q;
    tail_d    = tail_q;
    row_d     = row_q;
    row_vld_d = row_vld_q;
    for (int i = 0; i < NumWSlots; i++)
      if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - DelayWidth'(1);
    // Beats only reach the pre-existing head; a slot allocated this cycle is never the head yet
    if (beat_fire) beats_d[head_slot] = beats_q[head_slot] - BeatW'(1);
    if (pop)       head_d = ptr_inc(head_q);
    if (rel_fire)  occ_d[rel_idx] = 1'b0;
    if (alloc_fire) begin
      occ_d[alloc_idx]   = 1'b1;
      iid_d[alloc_idx]   = waddr_iid_i;
      cnt_d[alloc_idx]   = delay_m1;
      beats_d[alloc_idx] = BeatW'(waddr_burst_len_i) + BeatW'(1);
      fifo_d[tail_q]     = alloc_idx;
      tail_d             = ptr_inc(tail_q);
      row_d              = req_row;
      row_vld_d          = 1'b1;
    end
    qcnt_d = qcnt_q + CntW'(alloc_fire) - CntW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q     <= '0;
      iid_q     <= '0;
      cnt_q     <= '0;
      beats_q   <= '0;
      fifo_q    <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      qcnt_q    <= '0;
      row_q     <= '0;
      row_vld_q <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      iid_q     <= iid_d;
      cnt_q     <= cnt_d;
      beats_q   <= beats_d;
      fifo_q    <= fifo_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      qcnt_q    <= qcnt_d;
      row_q     <= row_d;
      row_vld_q <= row_vld_d;
    end
  end
endmodule

// File: tb/tb_simmem_write_delay_calc.sv
// Directed bench: expected (iid, release cycle) pairs are queued at stimulus time and
// matched against every release handshake the DUT performs.
module tb_simmem_write_delay_calc;
  logic        clk = 1'b0;
  logic        rst_i;
  logic        waddr_valid_i, waddr_ready_o;
  logic [4:0]  waddr_iid_i;
  logic [15:0] waddr_addr_i;
  logic [1:0]  waddr_burst_len_i;
  logic        wdata_valid_i, wdata_ready_o;
  logic        release_valid_o;
  logic [4:0]  release_iid_o;
  logic        release_ready_i;

  typedef struct { int iid; int cyc; } exp_t;
  exp_t sb[$];
  int   cyc = 0;
  int   nerr = 0;
  int   nchecks = 0;

  simmem_write_delay_calc dut (
    .clk_i(clk), .rst_i(rst_i),
    .waddr_valid_i(waddr_valid_i), .waddr_ready_o(waddr_ready_o),
    .waddr_iid_i(waddr_iid_i), .waddr_addr_i(waddr_addr_i),
    .waddr_burst_len_i(waddr_burst_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .release_valid_o(release_valid_o), .release_iid_o(release_iid_o),
    .release_ready_i(release_ready_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; cycle c runs until the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int iid, input int addr, input int len);
    chk("waddr_ready_at_req", waddr_ready_o, 1);
    waddr_valid_i     = 1'b1;
    waddr_iid_i       = 5'(iid);
    waddr_addr_i      = 16'(addr);
    waddr_burst_len_i = 2'(len);
  endtask

  task automatic push(input int iid, input int c);
    exp_t e;
    e.iid = iid;
    e.cyc = c;
    sb.push_back(e);
  endtask

  // Release monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (release_valid_o && release_ready_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_release_iid", 32'(release_iid_o), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("release_iid", 32'(release_iid_o), 32'(e.iid));
        chk("release_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int t;
    rst_i = 1'b1; waddr_valid_i = 1'b0; waddr_iid_i = '0; waddr_addr_i = '0;
    waddr_burst_len_i = '0; wdata_valid_i = 1'b0; release_ready_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_waddr_ready", waddr_ready_o, 1);
    chk("rst_wdata_ready", wdata_ready_o, 0);
    chk("rst_release_valid", release_valid_o, 0);
    chk("rst_release_iid", 32'(release_iid_o), 0);

    // Cold row: D=5, single beat right after acceptance
    t = cyc; req(3, 'h0100, 0); push(3, t + 5);
    tick(); waddr_valid_i = 1'b0; wdata_valid_i = 1'b1;
    tick(); wdata_valid_i = 1'b0;
    repeat (6) tick();

    // Row hit D=4, then row miss D=7
    t = cyc; req(4, 'h01F0, 0); push(4, t + 4);
    tick(); waddr_valid_i = 1'b0; wdata_valid_i = 1'b1;
    tick(); wdata_valid_i = 1'b0;
    repeat (5) tick();
    t = cyc; req(5, 'h0200, 0); push(5, t + 7);
    tick(); waddr_valid_i = 1'b0; wdata_valid_i = 1'b1;
    tick(); wdata_valid_i = 1'b0;
    repeat (8) tick();

    // Late data: 4 beats at T+10..T+13 hold the release until T+14
    t = cyc; req(6, 'h0200, 3); push(6, t + 14);
    tick(); waddr_valid_i = 1'b0;
    repeat (9) tick();
    wdata_valid_i = 1'b1;
    repeat (4) tick();
    wdata_valid_i = 1'b0;
    repeat (4) tick();

    // Fill all six slots without data, then stream the beats
    t = cyc;
    for (int i = 0; i < 6; i++) begin
      req(8 + i, 'h0200 + i * 4, 0);
      push(8 + i, t + 7 + i);
      tick();
    end
    waddr_valid_i = 1'b0;
    chk("full_waddr_ready", waddr_ready_o, 0);
    chk("full_wdata_ready", wdata_ready_o, 1);
    wdata_valid_i = 1'b1;
    repeat (6) tick();
    wdata_valid_i = 1'b0;
    chk("drained_wdata_ready", wdata_ready_o, 0);
    repeat (4) tick();

    // Backpressure: two eligible slots held while release_ready_i is low
    release_ready_i = 1'b0;
    req(20, 'h0200, 0);
    tick(); req(21, 'h0210, 0); wdata_valid_i = 1'b1;
    tick(); waddr_valid_i = 1'b0;
    tick(); wdata_valid_i = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      chk("hold_release_valid", release_valid_o, 1);
      chk("hold_release_iid", 32'(release_iid_o), 20);
      tick();
    end
    release_ready_i = 1'b1;
    push(20, cyc); push(21, cyc + 1);
    repeat (4) tick();

    // Reset with four requests pending: nothing may be released afterwards
    for (int i = 0; i < 4; i++) begin
      req(24 + i, 'h0300, 0);
      tick();
    end
    waddr_valid_i = 1'b0;
    chk("pending_wdata_ready", wdata_ready_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("midrst_waddr_ready", waddr_ready_o, 1);
    chk("midrst_wdata_ready", wdata_ready_o, 0);
    chk("midrst_release_valid", release_valid_o, 0);
    chk("midrst_release_iid", 32'(release_iid_o), 0);
    repeat (12) tick();

    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end
endmodule

// File: doc/simmem_write_delay_calc.md
SIMMEM_WRITE_DELAY_CALC -- requirements
Module: simmem_write_delay_calc

Interface
REQ-001 SHALL have parameter NumWSlots, default 6, number of concurrent write-request slots.
REQ-002 SHALL have parameter DelayWidth, default 6, width of each slot's delay counter.
REQ-003 SHALL have parameters RowHitCost/PrechargeCost/ActivationCost, defaults 4/2/1, cycle costs.
REQ-004 SHALL have parameter RowBufferLenWidth, default 8, number of column address bits below the row field.
REQ-005 clk_i  in  1  single clock, all state updates on rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 waddr_valid_i  in  1  write address request valid.
REQ-008 waddr_ready_o  out  1  a free slot exists.
REQ-009 waddr_iid_i  in  5  internal write identifier (write_iid_t) of the request.
REQ-010 waddr_addr_i  in  16  byte address (AxAddrWidth).
REQ-011 waddr_burst_len_i  in  2  beats minus one (MaxWBurstLenWidth).
REQ-012 wdata_valid_i  in  1  one write data beat present.
REQ-013 wdata_ready_o  out  1  some slot still awaits data beats.
REQ-014 release_valid_o  out  1  a write response may be released.
REQ-015 release_iid_o  out  5  iid to release, valid only with release_valid_o.
REQ-016 release_ready_i  in  1  response bank consumes the release.

Function
REQ-017 Each slot SHALL hold: occupied flag, iid, delay counter, beats-remaining count (3 bits).
REQ-018 Address handshake (waddr_valid_i & waddr_ready_o) SHALL allocate the lowest-index free slot.
REQ-019 waddr_ready_o SHALL be 1 iff at least one slot is unoccupied, from registered state only (a same-cycle release does not free a slot for that cycle).
REQ-020 Row = waddr_addr_i[15:RowBufferLenWidth]; block SHALL keep a registered open-row value plus a row-valid flag.
REQ-021 Delay D SHALL be: row-valid & row match -> RowHitCost (4); row-valid & mismatch -> PrechargeCost+ActivationCost+RowHitCost (7); row not valid -> ActivationCost+RowHitCost (5).
REQ-022 On acceptance, open row SHALL update to the request row and row-valid SHALL set; the next request is costed against it.
REQ-023 Accepted in cycle T, slot counter SHALL load D-1 and decrement by 1 per cycle, saturating at 0.
REQ-024 Beats-remaining SHALL load waddr_burst_len_i+1 on acceptance.
REQ-025 Block SHALL keep an in-order queue (depth NumWSlots) of slot indices awaiting data; wdata_ready_o = queue non-empty.
REQ-026 Data handshake SHALL decrement beats-remaining of the queue head; at 0 the head SHALL pop.
REQ-027 A slot accepted in cycle T SHALL NOT receive a beat in cycle T; beats in T apply to the pre-existing head only.
REQ-028 Slot eligible when occupied, counter==0, beats-remaining==0.
REQ-029 release_valid_o = any eligible slot; release_iid_o = iid of lowest-index eligible slot.
REQ-030 On release_valid_o & release_ready_i the selected slot SHALL become unoccupied at the next edge.
REQ-031 One release per cycle maximum; eligible slots with release_ready_i low SHALL hold state stably.
REQ-032 Earliest release_valid_o for a request accepted in T SHALL be cycle T+D, provided all beats arrived by then; otherwise the cycle after the last beat's handshake.
REQ-033 Allocate and release in the same cycle on different slots SHALL both take effect.

Reset
REQ-034 On rst_i high at a clock edge: all slots unoccupied, counters and beat counts 0, data queue empty, row-valid 0, open row 0.
REQ-035 Reset values: waddr_ready_o=1, wdata_ready_o=0, release_valid_o=0, release_iid_o=0.
REQ-036 Reset mid-operation SHALL discard all pending requests without issuing releases.

Verification
REQ-037 After reset, request iid=3 addr=0x0100 len=0 at T, beat at T+1, ready=1 -> release_valid_o at T+5 with iid 3.
REQ-038 Next request iid=4 addr=0x01F0 (same row) -> D=4; then iid=5 addr=0x0200 -> D=7.
REQ-039 Six requests, no beats -> waddr_ready_o=0 from the cycle after the sixth acceptance; wdata_ready_o=1.
REQ-040 Request len=3, beats delivered at T+10..T+13 -> release_valid_o first at T+14, not T+D.
REQ-041 Two slots eligible, release_ready_i=0 for 3 cycles -> release_iid_o constant (lower slot's iid), no slot freed.
REQ-042 rst_i asserted while 4 slots pending -> next cycle all outputs at reset values; no release observed.
